// File: rtl/mul_scoreboard_if.sv
// Signal bundle between the multiplier bench driver (master) and the result checker (slave).
interface mul_scoreboard_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 is_signed;
    logic [2*WIDTH-1:0]   product;
    logic                 finish;

    logic                 error;
    logic                 error_sticky;
    logic                 overflow;
    logic [CNT_W-1:0]     pending;
    logic [15:0]          pass_cnt;
    logic [15:0]          fail_cnt;

    modport master (
        output start, multiplicand, multiplier, is_signed, product, finish,
        input  error, error_sticky, overflow, pending, pass_cnt, fail_cnt
    );

    modport slave (
        input  start, multiplicand, multiplier, is_signed, product, finish,
        output error, error_sticky, overflow, pending, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/mul_scoreboard.sv
// Multiplier result checker: queues issued operand pairs and checks each DUT product in order.
// Optional head-of-queue latency watchdog enabled by defining MUL_SCOREBOARD_TIMEOUT_EN.
module mul_scoreboard #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rstn,
    mul_scoreboard_if.slave sb
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("mul_scoreboard: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    entry_t           head_c;
    logic [PW-1:0]    a_ext_c;
    logic [PW-1:0]    b_ext_c;
    logic [PW-1:0]    golden_c;

    logic             empty_c;
    logic             full_c;
    logic             check_c;
    logic             spurious_c;
    logic             timeout_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic             mismatch_c;
    logic             pass_ev_c;
    logic             fail_ev_c;

    // Golden product from the queue head; extension width makes the signed case fall out naturally
    assign head_c   = mem[rd_ptr];
    assign a_ext_c  = head_c.sgn ? {{WIDTH{head_c.a[WIDTH-1]}}, head_c.a}
                                 : {{WIDTH{1'b0}}, head_c.a};
    assign b_ext_c  = head_c.sgn ? {{WIDTH{head_c.b[WIDTH-1]}}, head_c.b}
                                 : {{WIDTH{1'b0}}, head_c.b};
    assign golden_c = a_ext_c * b_ext_c;

    assign empty_c    = (count == '0);
    assign full_c     = (count == CNT_W'(DEPTH));
    assign check_c    = sb.finish && !empty_c;
    assign spurious_c = sb.finish && empty_c;
    assign pop_c      = check_c || timeout_c;
    // A pop in the same cycle frees a slot, so a start on a full queue is still accepted
    assign push_c     = sb.start && (!full_c || pop_c);
    assign drop_c     = sb.start && full_c && !pop_c;
    assign mismatch_c = check_c && (sb.product != golden_c);
    assign pass_ev_c  = check_c && !mismatch_c;
    assign fail_ev_c  = mismatch_c || spurious_c || timeout_c;

`ifdef MUL_SCOREBOARD_TIMEOUT_EN
    localparam int unsigned AGE_W = $clog2(TIMEOUT + 1);

    logic [AGE_W-1:0] age;

    // A finish in the same cycle always beats the watchdog
    assign timeout_c = !sb.finish && !empty_c && (age == AGE_W'(TIMEOUT - 1));

    // Age of the current head entry; restarts for every new head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            age <= '0;
        end else if (pop_c || empty_c) begin
            age <= '0;
        end else begin
            age <= age + AGE_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // Entry storage needs no reset: only slots between rd_ptr and wr_ptr are ever read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{a: sb.multiplicand, b: sb.multiplier, sgn: sb.is_signed};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign sb.pending = count;

    // Check results, sticky flags and saturating counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb.error        <= 1'b0;
            sb.error_sticky <= 1'b0;
            sb.overflow     <= 1'b0;
            sb.pass_cnt     <= '0;
            sb.fail_cnt     <= '0;
        end else begin
            if (pass_ev_c) begin
                sb.error <= 1'b0;
                if (sb.pass_cnt != 16'hFFFF) begin
                    sb.pass_cnt <= sb.pass_cnt + 16'd1;
                end
            end else if (fail_ev_c) begin
                sb.error <= 1'b1;
                if (sb.fail_cnt != 16'hFFFF) begin
                    sb.fail_cnt <= sb.fail_cnt + 16'd1;
                end
            end
            if (fail_ev_c || drop_c) begin
                sb.error_sticky <= 1'b1;
            end
            if (drop_c) begin
                sb.overflow <= 1'b1;
            end
        end
    end
endmodule

// File: doc/mul_scoreboard.md
# mul_scoreboard

Parametrised multiplier result checker for the multiplier testbench. It sits beside the DUT on the same clock. Each `start` queues an operand pair with its signedness into an internal FIFO. Each `finish` pops the oldest pair and compares the DUT `product` against a golden product. It reports per-result error, sticky error, saturating pass/fail counters, FIFO overflow and an optional latency watchdog, so that pipelined and back-to-back multiplier operations can be checked.

## Interface
- `WIDTH`, 32, operand width; product is 2*WIDTH
- `DEPTH`, 4, number of outstanding operations queued (power of two, ≥2)
- `TIMEOUT`, 64, max cycles head entry may wait for `finish` (watchdog only)
- `clk`  in  1  clock, all state on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  operation issued to DUT this cycle
- `multiplicand`  in  WIDTH  operand A, sampled when `start`=1
- `multiplier`  in  WIDTH  operand B, sampled when `start`=1
- `is_signed`  in  1  1: two's-complement multiply, 0: unsigned; sampled with `start`
- `product`  in  2*WIDTH  DUT result, sampled when `finish`=1
- `finish`  in  1  DUT result valid this cycle
- `error`  out  1  result of last check: 1 = mismatch/spurious/timeout
- `error_sticky`  out  1  set on any failure, cleared only by reset
- `overflow`  out  1  sticky: `start` dropped because FIFO full
- `pending`  out  $clog2(DEPTH+1)  entries currently queued
- `pass_cnt`  out  16  saturating count of matching results
- `fail_cnt`  out  16  saturating count of failures

## Operation
- FIFO entry = {multiplicand, multiplier, is_signed}. Circular read/write pointers plus a count.
- Golden product is combinational from the FIFO head. Unsigned: zero-extend both operands to 2*WIDTH and multiply. Signed: sign-extend both operands to 2*WIDTH, multiply, and keep the low 2*WIDTH bits.
- `finish` with `pending`>0: pop the head and compare the full 2*WIDTH bits. On match: `error`←0, `pass_cnt`+1. On mismatch: `error`←1, `error_sticky`←1, `fail_cnt`+1.
- `finish` with `pending`=0 (spurious): `error`←1, `error_sticky`←1, `fail_cnt`+1, no pop.
- `start` with FIFO not full, or full with a pop in the same cycle: push the entry.
- `start` with FIFO full and no pop: entry dropped, `overflow`←1, `error_sticky`←1. Counters unchanged.
- Simultaneous `start`+`finish`: `finish` sees only entries queued before this cycle. On an empty FIFO, the `finish` is spurious and the new entry is pushed.
- Counters saturate at 16'hFFFF and do not wrap.
- `error` holds its value between checks.

## Timing
- Reset (async assert, sync release): FIFO empty, pointers 0, all outputs 0.
- `error`, counters and flags update on the clock edge that samples `finish`/`start`, so they are visible one cycle after the event.
- `pending` reflects push/pop one cycle after the edge.
- Minimum DUT latency is 1 cycle (`finish` may follow `start` on the next cycle). Back-to-back `finish` every cycle is supported.
- Reset mid-operation discards all queued entries. The next `finish` after reset is spurious unless a new `start` precedes it.

## Configuration
- `MUL_SCOREBOARD_TIMEOUT_EN` defined: an age counter runs while `pending`>0.
  - The counter resets to 0 on any pop and holds at 0 when the FIFO is empty.
  - When the counter reaches `TIMEOUT` without `finish`: pop the head, `error`←1, `error_sticky`←1, `fail_cnt`+1, counter←0.
  - If `finish` arrives in the same cycle as the timeout, the `finish` wins and no timeout is taken.
- Not defined: no counter logic; the head waits indefinitely.

## Test plan
- Unsigned, WIDTH=32: start A=32'h0000_FFFF, B=32'h0001_0000, finish 3 cycles later with product=64'h0000_0000_FFFF_0000 → `error`=0, `pass_cnt`=1.
- Signed: A=32'hFFFF_FFFE (−2), B=32'h0000_0003, is_signed=1, product=64'hFFFF_FFFF_FFFF_FFFA → pass. The same operands with is_signed=0 and that product → `error`=1, `error_sticky`=1.
- Pipelined ordering: 4 starts on consecutive cycles (2×3, 5×7, 0×9, FFFF_FFFF×FFFF_FFFF unsigned), then 4 finishes on consecutive cycles with 6, 35, 0, 64'hFFFF_FFFE_0000_0001 → `pass_cnt`=4, `pending` returns to 0. Swapping the first two results → `fail_cnt`=2.
- Full FIFO (DEPTH=4): 5 starts with no finish → `overflow`=1, `pending`=4. Then full plus simultaneous start+finish → push accepted, `pending` stays 4.
- Spurious: `finish` after reset with `pending`=0 → `error`=1, `fail_cnt`=1. Assert `rstn` low mid-queue → all outputs 0, `pending`=0.
- With `MUL_SCOREBOARD_TIMEOUT_EN`, TIMEOUT=8: one start, no finish → `fail_cnt`=1 and `pending`=0 after 8 cycles. A finish exactly at the timeout cycle → pass, no timeout.
